// File: rtl/game_round_sequencer_if.sv
// Bundles the button pulses, the switch value and the round status
// exchanged between the menu/button logic and the round sequencer.
interface game_round_sequencer_if;
    logic       Start;
    logic       Abort;
    logic       Submit;
    logic [7:0] userNumber;
    logic [7:0] target;
    logic [3:0] secondsLeft;
    logic [3:0] roundNum;
    logic [7:0] score;
    logic       isWrong;
    logic       busy;
    logic       done;

    // Menu / button side: issues the pulses and observes the round status.
    modport master (
        output Start, Abort, Submit, userNumber,
        input  target, secondsLeft, roundNum, score, isWrong, busy, done
    );

    // Sequencer side.
    modport slave (
        input  Start, Abort, Submit, userNumber,
        output target, secondsLeft, roundNum, score, isWrong, busy, done
    );
endinterface

// File: rtl/game_round_sequencer.sv
// Play-mode round sequencer: draws a target from a free-running LFSR,
// counts down the per-round timer, judges Submit, holds the result and
// keeps score until the configured number of rounds has been played.
module game_round_sequencer #(
    parameter int ROUNDS        = 10,
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int ROUND_SECS    = 10,
    parameter int RESULT_CYCLES = 50_000_000
) (
    input logic                   Clk,
    input logic                   Reset,
    game_round_sequencer_if.slave game
);

    localparam int TICK_W = $clog2(TICKS_PER_SEC);
    localparam int RES_W  = $clog2(RESULT_CYCLES + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [RES_W-1:0]  RES_LAST  = RES_W'(RESULT_CYCLES - 1);
    localparam logic [3:0]        SECS_INIT = 4'(ROUND_SECS);
    localparam logic [3:0]        LAST_ROUND = 4'(ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_RESULT,
        S_FINISH
    } state_t;

    state_t            state_reg,   state_next;
    logic [7:0]        lfsr_reg,    lfsr_next;
    logic [7:0]        target_reg,  target_next;
    logic [3:0]        secs_reg,    secs_next;
    logic [3:0]        round_reg,   round_next;
    logic [7:0]        score_reg,   score_next;
    logic              wrong_reg,   wrong_next;
    logic [TICK_W-1:0] tick_reg,    tick_next;
    logic [RES_W-1:0]  res_cnt_reg, res_cnt_next;

    logic lfsr_fb;
    logic tick_wrap;

    // x^8+x^6+x^5+x^4+1; a nonzero seed keeps the sequence off the all-zero lock-up
    assign lfsr_fb   = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
    assign tick_wrap = (tick_reg == TICK_LAST);

    // State and datapath registers, cleared or reseeded by the synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg   <= S_IDLE;
            lfsr_reg    <= 8'hA5;
            target_reg  <= '0;
            secs_reg    <= '0;
            round_reg   <= '0;
            score_reg   <= '0;
            wrong_reg   <= 1'b0;
            tick_reg    <= '0;
            res_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            lfsr_reg    <= lfsr_next;
            target_reg  <= target_next;
            secs_reg    <= secs_next;
            round_reg   <= round_next;
            score_reg   <= score_next;
            wrong_reg   <= wrong_next;
            tick_reg    <= tick_next;
            res_cnt_reg <= res_cnt_next;
        end
    end

    // Next-state and datapath updates; Abort outranks every other input
    always_comb begin
        state_next   = state_reg;
        lfsr_next    = {lfsr_reg[6:0], lfsr_fb};
        target_next  = target_reg;
        secs_next    = secs_reg;
        round_next   = round_reg;
        score_next   = score_reg;
        wrong_next   = wrong_reg;
        tick_next    = tick_reg;
        res_cnt_next = res_cnt_reg;

        if (game.Abort && (state_reg != S_IDLE)) begin
            state_next = S_IDLE;
            wrong_next = 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (game.Start) begin
                        state_next = S_LOAD;
                        score_next = '0;
                        round_next = '0;
                    end
                end
                S_LOAD: begin
                    target_next = lfsr_reg;
                    secs_next   = SECS_INIT;
                    tick_next   = '0;
                    round_next  = round_reg + 4'd1;
                    state_next  = S_WAIT;
                end
                S_WAIT: begin
                    tick_next = tick_wrap ? '0 : tick_reg + 1'b1;
                    if (game.Submit) begin
                        // A Submit on the final wrap wins; the timeout is dropped
                        state_next   = S_RESULT;
                        res_cnt_next = '0;
                        if (game.userNumber == target_reg) begin
                            wrong_next = 1'b0;
                            if (score_reg != 8'hFF) begin
                                score_next = score_reg + 8'd1;
                            end
                        end else begin
                            wrong_next = 1'b1;
                        end
                    end else if (tick_wrap) begin
                        secs_next = secs_reg - 4'd1;
                        if (secs_reg == 4'd1) begin
                            wrong_next   = 1'b1;
                            state_next   = S_RESULT;
                            res_cnt_next = '0;
                        end
                    end
                end
                S_RESULT: begin
                    if (res_cnt_reg == RES_LAST) begin
                        wrong_next = 1'b0;
                        state_next = (round_reg == LAST_ROUND) ? S_FINISH : S_LOAD;
                    end else begin
                        res_cnt_next = res_cnt_reg + 1'b1;
                    end
                end
                S_FINISH: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    assign game.target      = target_reg;
    assign game.secondsLeft = secs_reg;
    assign game.roundNum    = round_reg;
    assign game.score       = score_reg;
    assign game.isWrong     = wrong_reg;
    assign game.busy        = (state_reg != S_IDLE);
    assign game.done        = (state_reg == S_FINISH);

endmodule
